// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that reuses one CHUNK-wide
// full-adder slice across WIDTH/CHUNK cycles, with a registered carry
// between chunks.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
//   defined   -> signed overflow tap and ovf register are built
//   undefined -> ovf is tied to 0
//
// Parameters:
//   WIDTH  operand/result width (>= 1)
//   CHUNK  bits added per cycle; must divide WIDTH (N = WIDTH/CHUNK cycles)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, sampled only in IDLE
//   sub    0 = a+b+cin, 1 = a-b-cin
//   a, b   operands, captured on start
//   cin    carry-in / borrow-in, captured on start
//   sum    registered result, updated only on entry to DONE
//   cout   final carry (for subtract, 1 = no borrow)
//   ovf    signed two's-complement overflow
//   busy   high while chunks are being processed
//   done   one-cycle pulse when sum/cout/ovf become valid
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_chunk;
    logic             last_chunk;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operands shift right each cycle so the active chunk always sits at
    // bit 0; the result fills from the top, so after N cycles chunk k has
    // landed at bits k*CHUNK upward.
    always_comb begin
        a_chunk    = a_q[CHUNK-1:0];
        b_chunk    = b_q[CHUNK-1:0];
        {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
        res_nxt    = (res_q >> CHUNK) | (WIDTH'(s_chunk) << (WIDTH - CHUNK));
        last_chunk = (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        // Subtract is a + ~b + 1; a borrow-in removes the +1.
                        carry_q <= cin ^ sub;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    res_q   <= res_nxt;
                    carry_q <= c_chunk;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_chunk) begin
                        sum  <= res_nxt;
                        cout <= c_chunk;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
    logic msb_cin;

    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    always_comb begin
        msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                          ovf_q <= 1'b0;
        else if (state == RUN && last_chunk) ovf_q <= msb_cin ^ c_chunk;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (CHUNK = 1, 2, 4,
// WIDTH = 8) share stimulus; each has its own expected-result queue and
// monitor that also checks done latency and busy duration.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a, b;
    logic       cin;
    int         cyc = 0;

    int d_chk = 0;
    int d_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int CH = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
        localparam int NN = 8 / CH;

        logic [7:0] s;
        logic       co, ov, bz, dn;
        exp_t       q[$];
        int         bcnt = 0;
        int         m_chk = 0;
        int         m_err = 0;

        serial_adder #(.WIDTH(8), .CHUNK(CH)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .sub   (sub),
            .a     (a),
            .b     (b),
            .cin   (cin),
            .sum   (s),
            .cout  (co),
            .ovf   (ov),
            .busy  (bz),
            .done  (dn)
        );

        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                bcnt = 0;
            end else begin
                if (bz || dn) begin
                    m_chk++;
                    if (bz && dn) begin
                        m_err++;
                        $display("FAIL busy_done_overlap dut%0d: busy=%0b done=%0b, required not both high", gi, bz, dn);
                    end
                end
                if (bz) bcnt++;
                if (dn) begin
                    if (q.size() == 0) begin
                        m_chk++;
                        m_err++;
                        $display("FAIL unexpected_done dut%0d: done=1 at cycle %0d, required no done", gi, cyc);
                    end else begin
                        e = q.pop_front();
                        m_chk += 3;
                        if (s !== e.s || co !== e.c || ov !== e.o) begin
                            m_err++;
                            $display("FAIL result dut%0d: got sum=%02h cout=%0b ovf=%0b, required sum=%02h cout=%0b ovf=%0b",
                                     gi, s, co, ov, e.s, e.c, e.o);
                        end
                        if (cyc - e.t0 != NN) begin
                            m_err++;
                            $display("FAIL latency dut%0d: got %0d edges, required %0d", gi, cyc - e.t0, NN);
                        end
                        if (bcnt != NN) begin
                            m_err++;
                            $display("FAIL busy_cycles dut%0d: got %0d, required %0d", gi, bcnt, NN);
                        end
                    end
                    bcnt = 0;
                end
            end
        end
    end

    function automatic logic eff_ovf(input logic o);
`ifdef SERIAL_ADDER_OVF_EN
        return o;
`else
        return 1'b0 & o;
`endif
    endfunction

    task automatic push(input int d, input logic [7:0] es, input logic ec, input logic eo, input int t0);
        exp_t e;
        e.s  = es;
        e.c  = ec;
        e.o  = eff_ovf(eo);
        e.t0 = t0;
        case (d)
            0:       g[0].q.push_back(e);
            1:       g[1].q.push_back(e);
            default: g[2].q.push_back(e);
        endcase
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        d_chk++;
        if (act !== req) begin
            d_err++;
            $display("FAIL %s: got %02h, required %02h", nm, act, req);
        end
    endtask

    function automatic logic any_active();
        return g[0].bz || g[0].dn || g[1].bz || g[1].dn || g[2].bz || g[2].dn;
    endfunction

    task automatic wait_idle();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!any_active()) break;
        end
        if (k == 40) begin
            d_chk++;
            d_err++;
            $display("FAIL idle_timeout: still active after %0d cycles, required idle", k);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sum0"},  g[0].s, 8'h00);
        chk({tag, "_sum1"},  g[1].s, 8'h00);
        chk({tag, "_sum2"},  g[2].s, 8'h00);
        chk({tag, "_flags0"}, {3'b0, g[0].co, g[0].ov, g[0].bz, g[0].dn, 1'b0}, 8'h00);
        chk({tag, "_flags1"}, {3'b0, g[1].co, g[1].ov, g[1].bz, g[1].dn, 1'b0}, 8'h00);
        chk({tag, "_flags2"}, {3'b0, g[2].co, g[2].ov, g[2].bz, g[2].dn, 1'b0}, 8'h00);
    endtask

    // Issue one operation, then scramble inputs while it runs.
    task automatic issue(input logic s_i, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input logic [7:0] es, input logic ec, input logic eo);
        int t0;
        @(negedge clk);
        start = 1'b1; sub = s_i; a = av; b = bv; cin = ci;
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int d = 0; d < 3; d++) push(d, es, ec, eo, t0);
        start = 1'b0; sub = ~s_i; a = ~av; b = ~bv; cin = ~ci;
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int t0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        //     sub   a      b      cin   sum    cout  ovf
        issue(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        issue(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        issue(1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        issue(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        issue(1'b0, 8'hA5, 8'h5B, 1'b1, 8'h01, 1'b1, 1'b0);
        issue(1'b1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b1, 1'b0);
        issue(1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // start held high: first op uses 0x12+0x34, every re-accept
        // (at N+2 edges after the previous one) uses 0x40+0x40.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int d = 0; d < 3; d++) push(d, 8'h46, 1'b0, 1'b0, t0);
        a = 8'h40; b = 8'h40;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 4 || k == 8) push(2, 8'h80, 1'b0, 1'b1, t0 + k);
            if (k == 6)           push(1, 8'h80, 1'b0, 1'b1, t0 + k);
            if (k == 10) begin
                push(0, 8'h80, 1'b0, 1'b1, t0 + k);
                start = 1'b0;
            end
        end
        wait_idle();

        // Abort mid-RUN: outputs clear, and no done may follow.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 8'h11; b = 8'h22; cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("abort");
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        issue(1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0);

        chk("queue_empty0", 8'(g[0].q.size()), 8'h00);
        chk("queue_empty1", 8'(g[1].q.size()), 8'h00);
        chk("queue_empty2", 8'(g[2].q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d",
                 d_chk + g[0].m_chk + g[1].m_chk + g[2].m_chk,
                 d_err + g[0].m_err + g[1].m_err + g[2].m_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor. It processes two WIDTH-bit operands CHUNK bits per clock, using a registered carry between chunks, under a start/busy/done handshake. It is the sequential successor to the team's single-bit full adder: one CHUNK-wide full-adder slice is reused across cycles, so area stays small when WIDTH is large. It sits beside datapath blocks that tolerate multi-cycle latency.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 1.
- CHUNK, 1, bits added per cycle; must divide WIDTH exactly; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add (a+b+cin); 1 = subtract (a−b−cin).
- a  input  WIDTH  operand A; captured on start.
- b  input  WIDTH  operand B; captured on start.
- cin  input  1  carry-in (add) or borrow-in (sub); captured on start.
- sum  output  WIDTH  result; registered.
- cout  output  1  final carry. For subtract, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow. Present only under the configuration macro.
- busy  output  1  high while an operation is running.
- done  output  1  single-cycle pulse when the result becomes valid.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE with start=1:
  - a, b, sub and cin are latched into internal registers.
  - The effective B is ~b when sub=1, otherwise b.
  - The carry register is initialised to cin XOR sub.
  - The chunk counter is cleared to 0, and the FSM moves to RUN.
- IDLE with start=0: the FSM stays in IDLE.
- RUN, each cycle, for chunk index k (bits k·CHUNK to k·CHUNK+CHUNK−1):
  - Compute {c, s} = a_chunk + b_eff_chunk + carry.
  - Store s into the internal result register at chunk k, and store c into the carry register.
  - Increment k.
- RUN, on the cycle that processes chunk N−1:
  - Move to DONE.
  - Copy the internal result to sum, and the final carry to cout.
  - ovf = carry into the MSB XOR carry out of the MSB, taken from the MSB within the last chunk.
- DONE lasts exactly one cycle, then the FSM returns to IDLE.
- Output updates:
  - sum, cout and ovf change only on the transition into DONE.
  - They hold their values until the next completed operation.
  - They are never visible partially updated.
- start in RUN or DONE is ignored; it is not queued.
- Input changes after the start cycle have no effect on the operation in progress.
- Arithmetic is modulo 2^WIDTH. cout carries the (WIDTH+1)th bit.

## Timing
- Reset (rst_n=0 at a rising edge) forces:
  - state to IDLE and the counter to 0;
  - sum=0, cout=0, ovf=0, busy=0, done=0.
- Reset in RUN or DONE aborts the operation. No done pulse follows, and the previous sum is cleared to 0.
- Let E0 be the edge at which start is accepted.
  - busy is 1 from E0 until edge E_N (N cycles).
  - Chunks are processed at edges E1 through E_N.
  - After E_N, state is DONE: done=1, busy=0, and sum/cout/ovf are valid.
  - At E_{N+1}, done returns to 0 and the FSM is back in IDLE.
- Latency from start edge to done high is N edges.
- Minimum start-to-start spacing is N+2 cycles. A new start is accepted at E_{N+2} at the earliest.
- When CHUNK=WIDTH, N=1: busy is high for one cycle and done rises one edge after start.
- busy and done are never high in the same cycle.

## Configuration
- SERIAL_ADDER_OVF_EN:
  - Defined: the MSB carry-in tap and the ovf register are built, and ovf behaves as described above.
  - Undefined: the ovf port remains but is tied to constant 0, and no overflow logic is synthesised. All other behaviour is identical.

## Test plan
- WIDTH=8, CHUNK=1, add 0xFF+0x01, cin=0 → done 8 edges after start; sum=0x00, cout=1, ovf=0; busy high for exactly 8 cycles.
- WIDTH=8, CHUNK=1, add 0x7F+0x01, cin=0 → sum=0x80, cout=0, ovf=1 (0 with the macro undefined).
- WIDTH=8, CHUNK=2, sub 0x05−0x07, cin=0 → sum=0xFE, cout=0, ovf=0. Sub 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
- WIDTH=8, CHUNK=4, add 0xA5+0x5B, cin=1 → done 2 edges after start; sum=0x01, cout=1, ovf=0.
- start held high throughout, with changing a/b during RUN → only the first operands are used. The next operation is accepted exactly N+2 cycles after the first start edge.
- rst_n=0 asserted mid-RUN → next cycle busy=0, done=0, sum=0. No done pulse ever appears for the aborted operation.
